time_counter: RTL and testbench

Digital-clock timekeeping stage that consumes the divided clock level produced by the team's clock divider, e.g. 1 Hz at period 100000000.
- Detects each rising edge of that level in the system clock domain.
- Advances a BCD hh:mm:ss count on each edge; supports load, pause and an hh:mm alarm match.
- Its BCD digit outputs feed the seven-segment scan/display stage.

---
 rtl/time_counter_pkg.sv | 23 ++
 rtl/time_counter_if.sv | 31 +++
 rtl/time_counter_bcd.sv | 43 ++++
 rtl/time_counter.sv | 88 ++++++++
 tb/tb_time_counter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/time_counter_pkg.sv
// Shared BCD widths, moduli and helpers for the hh:mm:ss timekeeping slice.
package time_pkg;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PAIR_W  = 8;
    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;

    typedef logic [PAIR_W-1:0] bcd_pair_t;

    // True when both nibbles are decimal digits and the pair's value is below max.
    function automatic logic bcd_valid(input bcd_pair_t pair, input int unsigned max);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] units;
        tens  = pair[7:4];
        units = pair[3:0];
        if (tens > 4'd9 || units > 4'd9) return 1'b0;
        return ((32'(tens) * 32'd10) + 32'(units)) < max;
    endfunction

    function automatic bcd_pair_t to_bcd(input int unsigned v);
        return {4'(v / 32'd10), 4'(v % 32'd10)};
    endfunction
endpackage

// File: rtl/time_counter_if.sv
// Control, load, alarm and display signals of the time counter.
interface time_counter_if;
    logic       tick_clk;
    logic       run;
    logic       load;
    logic [7:0] load_hour;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       alarm_en;
    logic [7:0] alarm_hour;
    logic [7:0] alarm_min;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       sec_pulse;
    logic       day_pulse;
    logic       alarm_hit;
    logic       load_err;

    modport master (
        output tick_clk, run, load, load_hour, load_min, load_sec,
               alarm_en, alarm_hour, alarm_min,
        input  hour_bcd, min_bcd, sec_bcd, sec_pulse, day_pulse, alarm_hit, load_err
    );

    modport slave (
        input  tick_clk, run, load, load_hour, load_min, load_sec,
               alarm_en, alarm_hour, alarm_min,
        output hour_bcd, min_bcd, sec_bcd, sec_pulse, day_pulse, alarm_hit, load_err
    );
endinterface

// File: rtl/time_counter_bcd.sv
// Two-digit BCD modulo counter; carry flags the enabled wrap to 00.
module bcd_mod_counter
    import time_pkg::*;
#(
    parameter int unsigned MOD = 60
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_en,
    input  logic      i_load,
    input  bcd_pair_t i_load_val,
    output bcd_pair_t o_value,
    output bcd_pair_t o_next,
    output logic      o_carry
);
    localparam bcd_pair_t LAST = to_bcd(MOD - 1);

    bcd_pair_t r_value;
    bcd_pair_t w_next;

    always_comb begin
        w_next = r_value;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_en) begin
            if (r_value == LAST)
                w_next = '0;
            else if (r_value[3:0] == 4'd9)
                w_next = {r_value[7:4] + 4'd1, 4'd0};
            else
                w_next = {r_value[7:4], r_value[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_value <= '0;
        else      r_value <= w_next;
    end

    assign o_value = r_value;
    assign o_next  = w_next;
    assign o_carry = i_en & (r_value == LAST);
endmodule

// File: rtl/time_counter.sv
// BCD hh:mm:ss timekeeper advanced by rising edges of the divided tick level.
module time_counter
    import time_pkg::*;
#(
    parameter int unsigned HOUR_MOD = 24,
    parameter bit          INIT_RUN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    time_counter_if.slave bus
);
    logic      r_tick_q;
    logic      r_run_q;
    logic      r_sec_pulse;
    logic      r_day_pulse;
    logic      r_alarm_hit;
    logic      r_load_err;

    logic      w_tick_rise;
    logic      w_load_ok;
    logic      w_load_good;
    logic      w_load_bad;
    logic      w_adv;
    logic      w_sec_c;
    logic      w_min_c;
    logic      w_hour_c;
    logic      w_alarm;
    bcd_pair_t w_sec;
    bcd_pair_t w_min;
    bcd_pair_t w_hour;
    bcd_pair_t w_sec_next;
    bcd_pair_t w_min_next;
    bcd_pair_t w_hour_next;

    assign w_tick_rise = bus.tick_clk & ~r_tick_q;
    assign w_load_ok   = bcd_valid(bus.load_hour, HOUR_MOD) &
                         bcd_valid(bus.load_min, MIN_MOD) &
                         bcd_valid(bus.load_sec, SEC_MOD);
    assign w_load_good = bus.load & w_load_ok;
    assign w_load_bad  = bus.load & ~w_load_ok;
    // Any load, accepted or not, swallows a coincident tick.
    assign w_adv       = w_tick_rise & bus.run & r_run_q & ~bus.load;

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .rst(rst), .i_en(w_adv), .i_load(w_load_good),
        .i_load_val(bus.load_sec), .o_value(w_sec), .o_next(w_sec_next), .o_carry(w_sec_c)
    );
    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .rst(rst), .i_en(w_sec_c), .i_load(w_load_good),
        .i_load_val(bus.load_min), .o_value(w_min), .o_next(w_min_next), .o_carry(w_min_c)
    );
    bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .clk(clk), .rst(rst), .i_en(w_min_c), .i_load(w_load_good),
        .i_load_val(bus.load_hour), .o_value(w_hour), .o_next(w_hour_next), .o_carry(w_hour_c)
    );

    // Compare the post-advance value so the hit lines up with the displayed time.
    assign w_alarm = w_adv & bus.alarm_en &
                     (w_hour_next == bus.alarm_hour) &
                     (w_min_next == bus.alarm_min) &
                     (w_sec_next == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_q    <= 1'b0;
            r_run_q     <= INIT_RUN;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_tick_q    <= bus.tick_clk;
            r_run_q     <= bus.run;
            r_sec_pulse <= w_adv;
            r_day_pulse <= w_hour_c;
            r_alarm_hit <= w_alarm;
            r_load_err  <= w_load_bad;
        end
    end

    assign bus.hour_bcd  = w_hour;
    assign bus.min_bcd   = w_min;
    assign bus.sec_bcd   = w_sec;
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.day_pulse = r_day_pulse;
    assign bus.alarm_hit = r_alarm_hit;
    assign bus.load_err  = r_load_err;
endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench: directed vector table, corner sequences, random vs seconds-of-day model.
module tb_time_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    time_counter_if bus24();
    time_counter_if bus12();

    time_counter #(.HOUR_MOD(24), .INIT_RUN(1'b1)) u24 (.clk(clk), .rst(rst), .bus(bus24.slave));
    time_counter #(.HOUR_MOD(12), .INIT_RUN(1'b1)) u12 (.clk(clk), .rst(rst), .bus(bus12.slave));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       tick, run, load;
        logic [7:0] lh, lm, ls;
        logic       aen;
        logic [7:0] ah, am;
        logic [27:0] exp;
    } vec_t;
    vec_t vecs[$];

    // Model state: seconds since midnight and previous tick level.
    int   m_secs;
    logic m_tq;

    function automatic logic [7:0] enc(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int dec(input logic [7:0] p);
        return int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    function automatic logic pair_ok(input logic [7:0] p, input int lim);
        return (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9) && (dec(p) < lim);
    endfunction

    function automatic logic [27:0] pack(input logic [7:0] h, m, s, input logic sp, dp, hit, err);
        return {h, m, s, sp, dp, hit, err};
    endfunction

    function automatic void add(input logic tick, run, load, input logic [7:0] lh, lm, ls,
                                input logic aen, input logic [7:0] ah, am,
                                input logic [7:0] eh, em, es, input logic sp, dp, hit, err);
        vec_t v;
        v.tick = tick; v.run = run; v.load = load;
        v.lh = lh; v.lm = lm; v.ls = ls;
        v.aen = aen; v.ah = ah; v.am = am;
        v.exp = pack(eh, em, es, sp, dp, hit, err);
        vecs.push_back(v);
    endfunction

    function automatic logic [27:0] got24();
        return {bus24.hour_bcd, bus24.min_bcd, bus24.sec_bcd,
                bus24.sec_pulse, bus24.day_pulse, bus24.alarm_hit, bus24.load_err};
    endfunction

    function automatic logic [27:0] got12();
        return {bus12.hour_bcd, bus12.min_bcd, bus12.sec_bcd,
                bus12.sec_pulse, bus12.day_pulse, bus12.alarm_hit, bus12.load_err};
    endfunction

    task automatic cmp(input string name, input logic [27:0] got, input logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h:%h:%h sp=%b dp=%b al=%b er=%b exp=%h:%h:%h sp=%b dp=%b al=%b er=%b",
                     name, got[27:20], got[19:12], got[11:4], got[3], got[2], got[1], got[0],
                     exp[27:20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive24(input logic tick, run, load, input logic [7:0] lh, lm, ls,
                           input logic aen, input logic [7:0] ah, am);
        bus24.tick_clk = tick; bus24.run = run; bus24.load = load;
        bus24.load_hour = lh; bus24.load_min = lm; bus24.load_sec = ls;
        bus24.alarm_en = aen; bus24.alarm_hour = ah; bus24.alarm_min = am;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_cycle(input logic tick, run, load, input logic [7:0] lh, lm, ls,
                               input logic aen, input logic [7:0] ah, am, output logic [27:0] exp);
        logic rise, sp, dp, hit, err;
        rise = tick & ~m_tq;
        m_tq = tick;
        sp = 0; dp = 0; hit = 0; err = 0;
        if (load) begin
            if (pair_ok(lh, 24) && pair_ok(lm, 60) && pair_ok(ls, 60))
                m_secs = dec(lh) * 3600 + dec(lm) * 60 + dec(ls);
            else
                err = 1;
        end else if (rise && run) begin
            m_secs = (m_secs + 1) % 86400;
            sp = 1;
            dp = (m_secs == 0);
            hit = aen && (m_secs % 60 == 0) &&
                  (enc(m_secs / 3600) == ah) && (enc((m_secs / 60) % 60) == am);
        end
        exp = pack(enc(m_secs / 3600), enc((m_secs / 60) % 60), enc(m_secs % 60), sp, dp, hit, err);
    endtask

    initial begin
        logic [27:0] exp;
        logic tick, run, load, aen;
        logic [7:0] lh, lm, ls, ah, am;
        int nm;

        drive24(0, 1, 0, 0, 0, 0, 0, 0, 0);
        bus12.tick_clk = 0; bus12.run = 1; bus12.load = 0;
        bus12.load_hour = 0; bus12.load_min = 0; bus12.load_sec = 0;
        bus12.alarm_en = 0; bus12.alarm_hour = 0; bus12.alarm_min = 0;

        // Five plain ticks
        for (int i = 1; i <= 5; i++) begin
            add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, enc(i), 1, 0, 0, 0);
            add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, enc(i), 0, 0, 0, 0);
        end
        // Midnight wrap
        add(0, 1, 1, 8'h23, 8'h59, 8'h58, 0, 0, 0, 8'h23, 8'h59, 8'h58, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h23, 8'h59, 8'h59, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h23, 8'h59, 8'h59, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        // Alarm hit, alarm disabled, alarm time loaded directly
        add(0, 1, 1, 8'h08, 8'h59, 8'h59, 1, 8'h09, 8'h00, 8'h08, 8'h59, 8'h59, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1, 8'h09, 8'h00, 8'h09, 8'h00, 8'h00, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 8'h09, 8'h00, 8'h09, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 8'h08, 8'h59, 8'h59, 0, 8'h09, 8'h00, 8'h08, 8'h59, 8'h59, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 8'h09, 8'h00, 8'h09, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 8'h09, 8'h00, 8'h09, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 8'h09, 8'h00, 8'h00, 1, 8'h09, 8'h00, 8'h09, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 8'h09, 8'h00, 8'h09, 8'h00, 8'h00, 0, 0, 0, 0);
        // Rejected loads; the second one also drops a coincident tick
        add(0, 1, 1, 8'h12, 8'h6A, 8'h00, 0, 0, 0, 8'h09, 8'h00, 8'h00, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h09, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 1, 1, 8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h09, 8'h00, 8'h00, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h09, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 8'h09, 8'h00, 8'h60, 0, 0, 0, 8'h09, 8'h00, 8'h00, 0, 0, 0, 1);
        // Load beats tick, then hold across three ticks
        add(1, 1, 1, 8'h10, 8'h00, 8'h00, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            add(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0, 0);
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0, 0);
        end
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h01, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h01, 0, 0, 0, 0);

        step();
        step();
        cmp("reset_state", got24(), 28'h0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive24(vecs[i].tick, vecs[i].run, vecs[i].load, vecs[i].lh, vecs[i].lm, vecs[i].ls,
                    vecs[i].aen, vecs[i].ah, vecs[i].am);
            step();
            cmp($sformatf("vec%0d", i), got24(), vecs[i].exp);
        end

        // tick_clk held high for ten cycles gives one advance
        drive24(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        cmp("hold_high_first", got24(), pack(8'h10, 8'h00, 8'h02, 1, 0, 0, 0));
        for (int i = 0; i < 9; i++) begin
            step();
            cmp($sformatf("hold_high_%0d", i), got24(), pack(8'h10, 8'h00, 8'h02, 0, 0, 0, 0));
        end
        drive24(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Asynchronous reset mid-count
        drive24(0, 1, 1, 8'h04, 8'h05, 8'h06, 0, 0, 0);
        step();
        cmp("load_040506", got24(), pack(8'h04, 8'h05, 8'h06, 0, 0, 0, 0));
        drive24(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 cmp("async_reset", got24(), 28'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        cmp("post_reset_idle", got24(), 28'h0);
        drive24(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        cmp("post_reset_tick", got24(), pack(8'h00, 8'h00, 8'h01, 1, 0, 0, 0));
        drive24(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();

        // 12-hour instance: hour 12 rejected, 11:59:59 wraps to midnight
        bus12.load = 1; bus12.load_hour = 8'h12; bus12.load_min = 8'h00; bus12.load_sec = 8'h00;
        step();
        cmp("h12_reject_12", got12(), pack(8'h00, 8'h00, 8'h00, 0, 0, 0, 1));
        bus12.load_hour = 8'h11; bus12.load_min = 8'h59; bus12.load_sec = 8'h59;
        step();
        cmp("h12_load", got12(), pack(8'h11, 8'h59, 8'h59, 0, 0, 0, 0));
        bus12.load = 0; bus12.tick_clk = 1;
        step();
        cmp("h12_wrap", got12(), pack(8'h00, 8'h00, 8'h00, 1, 1, 0, 0));
        bus12.tick_clk = 0;
        step();
        cmp("h12_after_wrap", got12(), pack(8'h00, 8'h00, 8'h00, 0, 0, 0, 0));

        // Randomized run against the model, from a fresh reset
        rst = 1'b0;
        drive24(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        m_secs = 0;
        m_tq = 0;
        tick = 0; run = 1; aen = 1; ah = 0; am = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) tick = ~tick;
            // run only changes while the tick level is low
            if (!tick && $urandom_range(0, 19) == 0) run = ~run;
            load = ($urandom_range(0, 24) == 0);
            lh = 0; lm = 0; ls = 0;
            if (load) begin
                case ($urandom_range(0, 3))
                    0: begin lh = 8'h23; lm = 8'h59; ls = enc(int'($urandom_range(50, 59))); end
                    1: begin lh = 8'($urandom); lm = 8'($urandom); ls = 8'($urandom); end
                    default: begin
                        lh = enc(int'($urandom_range(0, 23)));
                        lm = enc(int'($urandom_range(0, 59)));
                        ls = enc(int'($urandom_range(45, 59)));
                    end
                endcase
            end
            if (c % 40 == 0) begin
                nm = (m_secs / 60 + 1) % 1440;
                ah = enc(nm / 60);
                am = enc(nm % 60);
                aen = ($urandom_range(0, 3) != 0);
            end
            drive24(tick, run, load, lh, lm, ls, aen, ah, am);
            model_cycle(tick, run, load, lh, lm, ls, aen, ah, am, exp);
            step();
            cmp($sformatf("rand%0d", c), got24(), exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
